// File: rtl/bus_pkg.sv
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared bus constants and destination-ID helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int              ID_W         = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int              MAX_PKT_W    = 256;

    // Callers zero-extend their packet to MAX_PKT_W and pass its real width.
    function automatic logic [ID_W-1:0] dest_of(
        input logic [MAX_PKT_W-1:0] pkt,
        input int                   pkt_w
    );
        return pkt[pkt_w-1 -: ID_W];
    endfunction

    function automatic logic dest_valid(
        input logic [ID_W-1:0] id,
        input int              term_id,
        input int              terminales,
        input logic [ID_W-1:0] bcast = BROADCAST_ID
    );
        logic ok;
        ok = 1'b0;
        if (32'(id) == term_id)
            ok = 1'b0;
        else if (id == bcast)
            ok = 1'b1;
        else if (32'(id) < terminales)
            ok = 1'b1;
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_fifo_ram.sv
// ============================================================================
//  Module      : bus_fifo_ram
//  Description : DEPTH x WIDTH storage, registered write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/bus_term_tx_fifo.sv
// ============================================================================
//  Module      : bus_term_tx_fifo
//  Description : Per-terminal first-word-fall-through transmit FIFO feeding
//                the bus arbiter. Define TX_FIFO_DEST_CHECK_EN to reject
//                packets with invalid or self destination IDs (adds bad_dest).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_term_tx_fifo
    import bus_pkg::*;
#(
    parameter int         ancho_pal  = 32,
    parameter int         depth      = 8,
    parameter int         terminales = 4,
    parameter logic [7:0] broadcast  = 8'hFF,
    parameter int         term_id    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ancho_pal-1:0]   wr_data,
    output logic                   full,
    input  logic                   pop,
    output logic                   pndng,
    output logic [ancho_pal-1:0]   D_pop,
    output logic [$clog2(depth):0] count,
    output logic                   overflow,
    output logic                   underflow
`ifdef TX_FIFO_DEST_CHECK_EN
    ,
    output logic                   bad_dest
`endif
);

    localparam int c_ptr_w = $clog2(depth);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 bad_dest_q, bad_dest_d;

    logic                 w_pndng;
    logic                 w_full;
    logic                 w_do_pop;
    logic                 w_wr_go;
    logic                 w_dest_ok;
    logic [ancho_pal-1:0] w_rdata;

`ifdef TX_FIFO_DEST_CHECK_EN
    logic [MAX_PKT_W-1:0] w_pkt_ext;
    assign w_pkt_ext = {{(MAX_PKT_W-ancho_pal){1'b0}}, wr_data};
    assign w_dest_ok = dest_valid(dest_of(w_pkt_ext, ancho_pal), term_id,
                                  terminales, broadcast);
`else
    assign w_dest_ok = 1'b1;
`endif

    always_comb begin
        w_pndng  = (count_q != '0);
        w_full   = (count_q == c_cnt_w'(depth));
        w_do_pop = pop & w_pndng;
        // A pop in the same cycle frees the slot a full FIFO needs.
        w_wr_go  = wr_en & w_dest_ok & (~w_full | w_do_pop);

        rd_ptr_d = w_do_pop ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        wr_ptr_d = w_wr_go  ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;

        count_d = count_q;
        if (w_wr_go && !w_do_pop)
            count_d = count_q + c_cnt_w'(1);
        else if (!w_wr_go && w_do_pop)
            count_d = count_q - c_cnt_w'(1);

        overflow_d  = wr_en & w_dest_ok & w_full & ~w_do_pop;
        underflow_d = pop & ~w_pndng;
        bad_dest_d  = wr_en & ~w_dest_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_dest_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            bad_dest_q  <= bad_dest_d;
        end
    end

    bus_fifo_ram #(
        .WIDTH (ancho_pal),
        .DEPTH (depth)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_go),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (w_rdata)
    );

    assign pndng     = w_pndng;
    assign full      = w_full;
    assign count     = count_q;
    assign D_pop     = w_pndng ? w_rdata : '0;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef TX_FIFO_DEST_CHECK_EN
    assign bad_dest  = bad_dest_q;
`else
    logic w_unused;
    assign w_unused = bad_dest_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_term_tx_fifo.sv
// ============================================================================
//  Module      : tb_bus_term_tx_fifo
//  Description : Self-checking bench: queue model plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_term_tx_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr_en = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] wr_data = '0;

    logic         full, pndng, overflow, underflow;
    logic [W-1:0] D_pop;
    logic [2:0]   count;
`ifdef TX_FIFO_DEST_CHECK_EN
    logic         bad_dest;
`endif

    bus_term_tx_fifo #(
        .ancho_pal  (W),
        .depth      (D),
        .terminales (4),
        .broadcast  (8'hFF),
        .term_id    (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .pop       (pop),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef TX_FIFO_DEST_CHECK_EN
        ,
        .bad_dest  (bad_dest)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: a plain queue of accepted packets.
    logic [W-1:0] q[$];
    bit m_ovf, m_unf, m_bad, chk_en;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                q.delete();
                m_ovf = 0; m_unf = 0; m_bad = 0;
            end else begin
                bit ok, popped;
                ok = 1;
`ifdef TX_FIFO_DEST_CHECK_EN
                ok = (wr_data[31:24] != 8'd0) &&
                     (wr_data[31:24] < 8'd4 || wr_data[31:24] == 8'hFF);
`endif
                m_bad  = wr_en && !ok;
                m_unf  = pop && (q.size() == 0);
                m_ovf  = 0;
                popped = pop && (q.size() > 0);
                if (popped)
                    void'(q.pop_front());
                if (wr_en && ok) begin
                    if (q.size() < D)
                        q.push_back(wr_data);
                    else
                        m_ovf = 1;
                end
            end
            chk_en = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_count", W'(count), W'(q.size()));
                check("m_pndng", W'(pndng), W'(q.size() != 0));
                check("m_full",  W'(full),  W'(q.size() == D));
                check("m_dpop",  D_pop, (q.size() != 0) ? q[0] : '0);
                check("m_ovf",   W'(overflow),  W'(m_ovf));
                check("m_unf",   W'(underflow), W'(m_unf));
`ifdef TX_FIFO_DEST_CHECK_EN
                check("m_bad",   W'(bad_dest),  W'(m_bad));
`endif
            end
        end
    end

    task automatic cyc(input logic w, input logic [W-1:0] d, input logic p);
        wr_en = w; wr_data = d; pop = p;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        cyc(1'b1, 32'h01000001, 1'b1);
        cyc(1'b1, 32'h01000001, 1'b1);
        check("rst_count", W'(count), 32'd0);
        check("rst_pndng", W'(pndng), 32'd0);
        check("rst_dpop",  D_pop, 32'd0);
        check("rst_pulses", W'({overflow, underflow, full}), 32'd0);
        reset = 1'b1;
        cyc(1'b0, '0, 1'b0);

`ifndef TX_FIFO_DEST_CHECK_EN
        for (int k = 1; k <= 4; k++)
            cyc(1'b1, W'(k), 1'b0);
        check("fill_full",  W'(full),  32'd1);
        check("fill_count", W'(count), 32'd4);
        cyc(1'b1, 32'h01BEEF05, 1'b0);
        check("ovf_pulse", W'(overflow), 32'd1);
        check("ovf_count", W'(count), 32'd4);
        cyc(1'b0, '0, 1'b0);
        check("ovf_once", W'(overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check("drain_dpop", D_pop, W'(k));
            cyc(1'b0, '0, 1'b1);
        end
        check("drain_empty", W'(pndng), 32'd0);
`else
        for (int k = 1; k <= 4; k++)
            cyc(1'b1, 32'h01000000 | W'(k), 1'b0);
        for (int k = 1; k <= 4; k++)
            cyc(1'b0, '0, 1'b1);
`endif

        cyc(1'b1, 32'h02000007, 1'b1);
        check("unf_pulse", W'(underflow), 32'd1);
        check("unf_count", W'(count), 32'd1);
        check("unf_dpop",  D_pop, 32'h02000007);
        cyc(1'b0, '0, 1'b1);

        for (int k = 10; k <= 13; k++)
            cyc(1'b1, 32'h01000000 | W'(k), 1'b0);
        cyc(1'b1, 32'h03000009, 1'b1);
        check("fwp_count", W'(count), 32'd4);
        check("fwp_noovf", W'(overflow), 32'd0);
        check("fwp_head",  D_pop, 32'h0100000B);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, '0, 1'b1);
        check("fwp_last", D_pop, 32'h03000009);
        cyc(1'b0, '0, 1'b1);
        check("fwp_empty", W'(pndng), 32'd0);

`ifdef TX_FIFO_DEST_CHECK_EN
        cyc(1'b1, 32'h07000000, 1'b0);
        check("dst_bad_range", W'(bad_dest), 32'd1);
        check("dst_range_cnt", W'(count), 32'd0);
        cyc(1'b1, 32'h00000000, 1'b0);
        check("dst_bad_self", W'(bad_dest), 32'd1);
        check("dst_self_cnt", W'(count), 32'd0);
        cyc(1'b1, 32'hFF000000, 1'b0);
        check("dst_bcast_ok", W'(bad_dest), 32'd0);
        check("dst_bcast_cnt", W'(count), 32'd1);
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h02000000 | W'(k), 1'b0);
        cyc(1'b1, 32'h09000000, 1'b0);
        check("dst_full_noovf", W'(overflow), 32'd0);
        check("dst_full_bad", W'(bad_dest), 32'd1);
`else
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h02000000 | W'(k), 1'b0);
        check("part_count", W'(count), 32'd3);
`endif

        reset = 1'b0;
        cyc(1'b1, 32'h01000055, 1'b1);
        check("mid_rst_count", W'(count), 32'd0);
        check("mid_rst_dpop",  D_pop, 32'd0);
        reset = 1'b1;
        cyc(1'b1, 32'h01000066, 1'b0);
        check("post_rst_dpop", D_pop, 32'h01000066);
        cyc(1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_term_tx_fifo.md
Name: bus_term_tx_fifo

Overview:
Per-terminal transmit FIFO sitting directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- Buffers packets written by the terminal's source.
- Presents the head packet to the bus as first-word fall-through on D_pop, with pndng asserted while non-empty.
- Retires the head entry on the bus's pop strobe.
- One instance per terminal; the top level instantiates `drvrs` copies.

Parameters:
- ancho_pal, 32, packet width in bits; bits [ancho_pal-1 -: 8] hold the destination ID.
- depth, 8, FIFO entries; power of two, ≥2.
- terminales, 4, number of bus terminals; valid destination IDs are 0..terminales-1.
- broadcast, 8'hFF, destination ID meaning all terminals.
- term_id, 0, this terminal's own ID.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  source write strobe.
- wr_data  input  ancho_pal  packet to enqueue.
- full  output  1  no free entries.
- pop  input  1  bus retires the head entry (from bus pop[0][term_id]).
- pndng  output  1  head valid (to bus pndng[term_id]).
- D_pop  output  ancho_pal  head packet (to bus D_pop[term_id]).
- count  output  $clog2(depth)+1  occupancy.
- overflow  output  1  one-cycle pulse: write dropped.
- underflow  output  1  one-cycle pulse: pop while empty.

Behaviour:
- Reset is sampled at the rising clk edge while reset==0.
  - Clears rd_ptr, wr_ptr and count to 0.
  - Drives pndng=0, full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset has priority over wr_en and pop in the same cycle. Any queued packets are lost; the head is not retired to the bus.
- Pointers are $clog2(depth) bits and wrap modulo depth. count is held separately, range 0..depth.
- Derived outputs:
  - pndng = (count!=0).
  - full = (count==depth).
  - D_pop = mem[rd_ptr] when pndng, else all zeros. This is combinational from registered state: zero-latency fall-through.
- Write latency: a packet written at edge N appears on D_pop, with pndng=1, after edge N when the FIFO was empty. It appears 1 cycle after the write, never in the same cycle.
- Pop:
  - pop with pndng=1: rd_ptr increments and count decrements at that edge. The next entry, if any, is on D_pop in the following cycle.
  - pop with pndng=0: no state change; underflow pulses in the next cycle.
- Write:
  - wr_en with full=0: writes mem[wr_ptr], then wr_ptr increments and count increments.
  - wr_en with full=1 and pop=0: data is dropped and overflow pulses in the next cycle.
- Simultaneous wr_en and pop:
  - Non-empty and not full: both occur; count is unchanged.
  - Full: the pop frees a slot, the write is accepted, count stays at depth, no overflow.
  - Empty: the write is accepted, the pop is ignored, underflow pulses, count becomes 1.
- Storage FSM: no explicit FSM. States are implied by count (EMPTY, PARTIAL, FULL), and transitions follow the rules above.

Optional Feature:
- Macro: TX_FIFO_DEST_CHECK_EN.
- Defined:
  - A write is rejected (not enqueued, no pointer or count change) when the destination ID is ≥terminales and ≠broadcast, or equals term_id.
  - Adds output port bad_dest, which pulses for 1 cycle after the rejected write.
  - A rejected write never raises overflow, even when full.
- Undefined: all packets are enqueued regardless of destination ID; the bad_dest port does not exist.

Decomposition:
- Package bus_pkg holds:
  - ID_W=8.
  - BROADCAST_ID=8'hFF.
  - Function dest_of(pkt) returning the top ID_W bits.
  - Function dest_valid(id, term_id, terminales), used by the optional check.
- Sub-module bus_fifo_ram: depth×ancho_pal storage with registered write port and asynchronous read port. Pointer and count logic stay in the top module.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with wr_en=1 and pop=1 → count=0, pndng=0, D_pop=0, no pulses.
- Fill and drain (depth=4): write 32'h00000001..04 on 4 consecutive cycles → full=1, count=4. Then pop on 4 consecutive cycles → D_pop sequence 1,2,3,4, then pndng=0.
- Overflow: at full, write 32'h01BEEF05 → overflow pulses once, count stays 4, drained data is still 1..4.
- Underflow plus simultaneous write: while empty, assert pop and write 32'h02000007 in the same cycle → underflow pulses, count=1, D_pop=32'h02000007 next cycle.
- Full with simultaneous write and pop: at full, write 32'h03000009 and pop → count stays 4, no overflow, the last drained word is 32'h03000009.
- Destination check (TX_FIFO_DEST_CHECK_EN, terminales=4, term_id=0):
  - Writing 32'h07000000 → bad_dest pulse, count unchanged.
  - Writing 32'h00000000 (self-addressed) → bad_dest pulse, count unchanged.
  - Writing 32'hFF000000 → accepted.
